// File: rtl/axi4_ram_pkg.sv
// axi4_ram_pkg: burst/response encodings and FSM states shared by the AXI4 RAM slave
package axi4_ram_pkg;
  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] BURST_INCR  = 2'b01;
  localparam logic [1:0] BURST_WRAP  = 2'b10;
  localparam logic [1:0] BURST_RSVD  = 2'b11;
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  typedef enum logic [2:0] {IDLE, WDATA, WRESP, RADDR, RDATA} state_t;
endpackage

// File: rtl/ram_sp_be.sv
// ram_sp_be: single-port byte-enable RAM with synchronous read, output held between reads
module ram_sp_be #(
  parameter int DEPTH  = 1024,
  parameter int DATA_W = 32
) (
  input  logic                     clk,
  input  logic [$clog2(DEPTH)-1:0] addr,
  input  logic [DATA_W/8-1:0]      we,
  input  logic                     re,
  input  logic [DATA_W-1:0]        wdata,
  output logic [DATA_W-1:0]        rdata
);
  logic [DATA_W-1:0] mem [DEPTH];
  always_ff @(posedge clk) begin
    for (int i = 0; i < DATA_W/8; i++)
      if (we[i]) mem[addr][8*i +: 8] <= wdata[8*i +: 8];
    if (re) rdata <= mem[addr];
  end
endmodule

// File: rtl/axi4_ram_slave.sv
// axi4_ram_slave: AXI4 slave word RAM, one transaction at a time with alternating read/write arbitration
module axi4_ram_slave
  import axi4_ram_pkg::*;
#(
  parameter int ADDR_W = 12,
  parameter int ID_W   = 4
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            inport_awvalid_i,
  input  logic [31:0]     inport_awaddr_i,
  input  logic [ID_W-1:0] inport_awid_i,
  input  logic [7:0]      inport_awlen_i,
  input  logic [1:0]      inport_awburst_i,
  output logic            inport_awready_o,
  input  logic            inport_wvalid_i,
  input  logic [31:0]     inport_wdata_i,
  input  logic [3:0]      inport_wstrb_i,
  input  logic            inport_wlast_i,
  output logic            inport_wready_o,
  output logic            inport_bvalid_o,
  output logic [1:0]      inport_bresp_o,
  output logic [ID_W-1:0] inport_bid_o,
  input  logic            inport_bready_i,
  input  logic            inport_arvalid_i,
  input  logic [31:0]     inport_araddr_i,
  input  logic [ID_W-1:0] inport_arid_i,
  input  logic [7:0]      inport_arlen_i,
  input  logic [1:0]      inport_arburst_i,
  output logic            inport_arready_o,
  output logic            inport_rvalid_o,
  output logic [31:0]     inport_rdata_o,
  output logic [1:0]      inport_rresp_o,
  output logic [ID_W-1:0] inport_rid_o,
  output logic            inport_rlast_o,
  input  logic            inport_rready_i
);
  localparam int AW = ADDR_W - 2;
  state_t            state;
  logic [AW-1:0]     addr_q, addr_n;
  logic [7:0]        len_q;
  logic [1:0]        burst_q, bresp_q;
  logic [ID_W-1:0]   id_q;
  logic [8:0]        beat_q, beat_n;
  logic              last_wr, idle, aw_acc, ar_acc, at_end, rsvd, bad;
  logic [31:0]       ram_q;
  logic              unused;
  assign unused = ^{inport_awaddr_i[31:ADDR_W], inport_awaddr_i[1:0],
                    inport_araddr_i[31:ADDR_W], inport_araddr_i[1:0]};
  // When both channels request, the one not served last wins; after reset that is the write.
  assign idle   = state == IDLE && !rst_i;
  assign aw_acc = idle && inport_awvalid_i && (!inport_arvalid_i || !last_wr);
  assign ar_acc = idle && inport_arvalid_i && !aw_acc;
  assign beat_n = beat_q + 9'd1;
  assign at_end = beat_n == {1'b0, len_q} + 9'd1;
  assign rsvd   = burst_q == BURST_RSVD;
  assign bad    = inport_wlast_i != at_end;
  assign addr_n = burst_q == BURST_FIXED ? addr_q : addr_q + AW'(1);
  ram_sp_be #(.DEPTH(1 << AW), .DATA_W(32)) u_ram (
    .clk   (clk_i),
    .addr  (addr_q),
    .we    (state == WDATA && inport_wvalid_i && !rsvd ? inport_wstrb_i : 4'h0),
    .re    (state == RADDR),
    .wdata (inport_wdata_i),
    .rdata (ram_q)
  );
  assign inport_awready_o = aw_acc;
  assign inport_arready_o = ar_acc;
  assign inport_wready_o  = state == WDATA;
  assign inport_bvalid_o  = state == WRESP;
  assign inport_bresp_o   = inport_bvalid_o ? bresp_q : RESP_OKAY;
  assign inport_bid_o     = inport_bvalid_o ? id_q : '0;
  assign inport_rvalid_o  = state == RDATA;
  assign inport_rdata_o   = inport_rvalid_o ? ram_q : 32'h0;
  assign inport_rresp_o   = inport_rvalid_o && rsvd ? RESP_SLVERR : RESP_OKAY;
  assign inport_rid_o     = inport_rvalid_o ? id_q : '0;
  assign inport_rlast_o   = inport_rvalid_o && beat_q == {1'b0, len_q};
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state   <= IDLE;
      addr_q  <= '0;
      len_q   <= '0;
      burst_q <= BURST_FIXED;
      id_q    <= '0;
      beat_q  <= '0;
      bresp_q <= RESP_OKAY;
      last_wr <= 1'b0;
    end else begin
      case (state)
        IDLE: if (aw_acc || ar_acc) begin
          addr_q  <= aw_acc ? inport_awaddr_i[ADDR_W-1:2] : inport_araddr_i[ADDR_W-1:2];
          len_q   <= aw_acc ? inport_awlen_i : inport_arlen_i;
          burst_q <= aw_acc ? inport_awburst_i : inport_arburst_i;
          id_q    <= aw_acc ? inport_awid_i : inport_arid_i;
          beat_q  <= '0;
          state   <= aw_acc ? WDATA : RADDR;
        end
        WDATA: if (inport_wvalid_i) begin
          beat_q <= beat_n;
          addr_q <= addr_n;
          if (inport_wlast_i || at_end) begin
            bresp_q <= bad || rsvd ? RESP_SLVERR : RESP_OKAY;
            state   <= WRESP;
          end
        end
        WRESP: if (inport_bready_i) begin
          last_wr <= 1'b1;
          state   <= IDLE;
        end
        RADDR: begin
          addr_q <= addr_n;
          state  <= RDATA;
        end
        RDATA: if (inport_rready_i) begin
          beat_q <= beat_n;
          state  <= inport_rlast_o ? IDLE : RADDR;
          if (inport_rlast_o) last_wr <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_axi4_ram_slave.sv
// tb_axi4_ram_slave: randomized and directed AXI4 traffic against a word-array reference memory
module tb_axi4_ram_slave;
  logic        clk, rst;
  logic        awvalid, awready, wvalid, wlast, wready, bvalid, bready;
  logic        arvalid, arready, rvalid, rlast, rready;
  logic [31:0] awaddr, araddr, wdata, rdata;
  logic [3:0]  awid, arid, bid, rid, wstrb;
  logic [7:0]  awlen, arlen;
  logic [1:0]  awburst, arburst, bresp, rresp;
  int          n_tests = 0, n_fail = 0;
  logic [31:0] model [1024];
  logic [31:0] wd [256];
  logic [3:0]  ws [256];
  logic        last_wr_m;
  axi4_ram_slave dut (
    .clk_i(clk), .rst_i(rst),
    .inport_awvalid_i(awvalid), .inport_awaddr_i(awaddr), .inport_awid_i(awid),
    .inport_awlen_i(awlen), .inport_awburst_i(awburst), .inport_awready_o(awready),
    .inport_wvalid_i(wvalid), .inport_wdata_i(wdata), .inport_wstrb_i(wstrb),
    .inport_wlast_i(wlast), .inport_wready_o(wready),
    .inport_bvalid_o(bvalid), .inport_bresp_o(bresp), .inport_bid_o(bid), .inport_bready_i(bready),
    .inport_arvalid_i(arvalid), .inport_araddr_i(araddr), .inport_arid_i(arid),
    .inport_arlen_i(arlen), .inport_arburst_i(arburst), .inport_arready_o(arready),
    .inport_rvalid_o(rvalid), .inport_rdata_o(rdata), .inport_rresp_o(rresp),
    .inport_rid_o(rid), .inport_rlast_o(rlast), .inport_rready_i(rready)
  );
  initial clk = 0;
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  function automatic logic sig(input int w);
    return w == 0 ? awready : w == 1 ? wready : w == 2 ? bvalid : w == 3 ? arready : rvalid;
  endfunction
  task automatic wait_hi(input int w, input string tag, output int t);
    t = 0;
    #1;
    while (!sig(w) && t < 40) begin
      @(negedge clk);
      #1;
      t++;
    end
    if (!sig(w)) check({tag, "_timeout"}, 0, 1);
  endtask
  task automatic axi_write(input logic [31:0] addr, input logic [7:0] len, input logic [1:0] burst,
                           input logic [3:0] id, input int last_at);
    int nb, t;
    logic [9:0] a;
    logic [1:0] er;
    nb = (last_at >= 1 && last_at <= len + 1) ? last_at : len + 1;
    @(negedge clk);
    awaddr = addr; awlen = len; awburst = burst; awid = id; awvalid = 1;
    wait_hi(0, "awready", t);
    @(negedge clk);
    awvalid = 0;
    for (int b = 0; b < nb; b++) begin
      wdata = wd[b]; wstrb = ws[b]; wlast = (b + 1 == last_at); wvalid = 1;
      wait_hi(1, "wready", t);
      @(negedge clk);
    end
    wvalid = 0; wlast = 0;
    a = addr[11:2];
    for (int b = 0; b < nb; b++) begin
      if (burst != 2'b11)
        for (int i = 0; i < 4; i++) if (ws[b][i]) model[a][8*i +: 8] = wd[b][8*i +: 8];
      if (burst != 2'b00) a = a + 10'd1;
    end
    er = (burst == 2'b11 || last_at != len + 1) ? 2'b10 : 2'b00;
    wait_hi(2, "bvalid", t);
    repeat ($urandom_range(0, 2)) begin
      @(negedge clk);
      #1 check("bvalid_hold", bvalid, 1);
    end
    bready = 1;
    check("bresp", bresp, er);
    check("bid", bid, id);
    @(negedge clk);
    bready = 0;
    #1 check("bvalid_drop", bvalid, 0);
    last_wr_m = 1;
  endtask
  task automatic axi_read(input logic [31:0] addr, input logic [7:0] len, input logic [1:0] burst,
                          input logic [3:0] id, input int stall);
    int t;
    logic [9:0] a;
    @(negedge clk);
    araddr = addr; arlen = len; arburst = burst; arid = id; arvalid = 1;
    wait_hi(3, "arready", t);
    @(negedge clk);
    arvalid = 0;
    a = addr[11:2];
    for (int b = 0; b <= len; b++) begin
      wait_hi(4, "rvalid", t);
      if (b == 0) check("rd_latency", t, 1);
      repeat (stall) begin
        @(negedge clk);
        #1 check("rdata_stall", rdata, model[a]);
        check("rvalid_stall", rvalid, 1);
      end
      check("rdata", rdata, model[a]);
      check("rlast", rlast, b == len);
      check("rid", rid, id);
      check("rresp", rresp, burst == 2'b11 ? 2'b10 : 2'b00);
      rready = 1;
      @(negedge clk);
      rready = 0;
      if (burst != 2'b00) a = a + 10'd1;
    end
    #1 check("rvalid_end", rvalid, 0);
    last_wr_m = 0;
  endtask
  task automatic arb_check;
    @(negedge clk);
    awaddr = 0; araddr = 0; awlen = 0; arlen = 0; awburst = 1; arburst = 1;
    awvalid = 1; arvalid = 1;
    #1;
    check("arb_awready", awready, !last_wr_m);
    check("arb_arready", arready, last_wr_m);
    awvalid = 0; arvalid = 0;
  endtask
  initial begin
    int t;
    logic [7:0] len;
    rst = 1; awvalid = 1; wvalid = 0; wlast = 0; bready = 0; arvalid = 0; rready = 0;
    awaddr = 0; araddr = 0; awid = 0; arid = 0; awlen = 0; arlen = 0; awburst = 0; arburst = 0;
    wdata = 0; wstrb = 0; last_wr_m = 0;
    #2;
    check("rst_awready", awready, 0);
    check("rst_wready", wready, 0);
    check("rst_bvalid", bvalid, 0);
    check("rst_arready", arready, 0);
    check("rst_rvalid", rvalid, 0);
    check("rst_rdata", rdata, 0);
    check("rst_rlast", rlast, 0);
    repeat (3) @(negedge clk);
    awvalid = 0; rst = 0;
    arb_check();
    for (int k = 0; k < 4; k++) begin
      for (int b = 0; b < 256; b++) begin wd[b] = $urandom; ws[b] = 4'hF; end
      axi_write(32'(k) * 32'h400, 8'd255, 2'b01, 4'(k), 256);
    end
    arb_check();
    wd[0] = 32'hDEADBEEF; ws[0] = 4'hF;
    axi_write(32'h10, 0, 2'b01, 4'd2, 1);
    axi_read(32'h10, 0, 2'b01, 4'd3, 0);
    arb_check();
    for (int b = 0; b < 4; b++) begin wd[b] = 32'(b + 1); ws[b] = 4'hF; end
    axi_write(32'h100, 3, 2'b01, 4'd1, 4);
    axi_read(32'h100, 3, 2'b01, 4'd5, 0);
    wd[0] = 32'hFFFFFFFF; ws[0] = 4'hF;
    axi_write(32'h20, 0, 2'b01, 4'd1, 1);
    wd[0] = 32'h0; ws[0] = 4'h5;
    axi_write(32'h20, 0, 2'b01, 4'd1, 1);
    axi_read(32'h20, 0, 2'b01, 4'd1, 0);
    for (int b = 0; b < 4; b++) begin wd[b] = $urandom; ws[b] = 4'hF; end
    axi_write(32'h200, 3, 2'b01, 4'd6, 2);
    axi_read(32'h200, 3, 2'b01, 4'd6, 0);
    axi_write(32'h300, 1, 2'b11, 4'd7, 2);
    axi_read(32'h300, 1, 2'b01, 4'd7, 0);
    axi_write(32'h340, 1, 2'b01, 4'd8, 0);
    axi_read(32'h340, 1, 2'b01, 4'd8, 0);
    axi_write(32'hFFC, 1, 2'b01, 4'd9, 2);
    axi_read(32'hFFC, 1, 2'b01, 4'd9, 0);
    axi_read(32'h000, 0, 2'b01, 4'd9, 0);
    axi_write(32'h400, 2, 2'b00, 4'd10, 3);
    axi_read(32'h400, 2, 2'b00, 4'd10, 0);
    axi_read(32'h404, 0, 2'b01, 4'd10, 0);
    axi_read(32'h100, 1, 2'b01, 4'd5, 5);
    axi_read(32'h1010, 0, 2'b10, 4'd11, 0);
    @(negedge clk);
    araddr = 32'h100; arlen = 3; arburst = 1; arid = 4'd12; arvalid = 1;
    wait_hi(3, "arready", t);
    @(negedge clk);
    arvalid = 0;
    wait_hi(4, "rvalid", t);
    rst = 1;
    awvalid = 1;
    #1;
    check("rst_mid_rvalid", rvalid, 0);
    check("rst_mid_rdata", rdata, 0);
    check("rst_mid_awready", awready, 0);
    @(negedge clk);
    rst = 0; awvalid = 0; last_wr_m = 0;
    arb_check();
    axi_read(32'h100, 3, 2'b01, 4'd12, 0);
    for (int n = 0; n < 40; n++) begin
      len = 8'($urandom_range(0, 7));
      if ($urandom_range(0, 4) == 0) arb_check();
      if ($urandom_range(0, 1) == 1) begin
        for (int b = 0; b < 256; b++) begin wd[b] = $urandom; ws[b] = 4'($urandom); end
        axi_write($urandom, len, 2'($urandom_range(0, 2)), 4'($urandom),
                  $urandom_range(0, 3) == 0 ? int'($urandom_range(0, len + 1)) : len + 1);
      end else
        axi_read($urandom, len, 2'($urandom_range(0, 2)), 4'($urandom), $urandom_range(0, 2));
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
